// File: rtl/cic_comb.sv
// cic_comb: N cascaded comb stages y[n] = x[n] - x[n-M] at IW bits, then scaled to OW bits.
// Define CIC_COMB_ROUND_EN for round-half-up with positive saturation when OW < IW.
module cic_comb #(
  parameter int IW = 37,
  parameter int N  = 3,
  parameter int M  = 1,
  parameter int OW = 37
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [IW-1:0] din,
  input  logic                 din_vld,
  output logic signed [OW-1:0] dout,
  output logic                 dout_vld
);

  localparam int SHIFT = IW - OW;

  logic signed [IW-1:0] r_stage [N];
  logic signed [IW-1:0] r_dly   [N][M];
  logic [N-1:0]         r_vld;
  logic signed [OW-1:0] r_dout;
  logic                 r_dout_vld;

  logic signed [IW-1:0] w_x [N];
  logic [N-1:0]         w_v;
  logic signed [OW-1:0] w_scaled;

  // Stage k consumes the previous stage's register and valid bit; stage 0 consumes din.
  always_comb begin
    w_v    = '0;
    w_x[0] = din;
    w_v[0] = din_vld;
    for (int unsigned k = 1; k < N; k++) begin
      w_x[k] = r_stage[k-1];
      w_v[k] = r_vld[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_vld      <= '0;
      r_dout     <= '0;
      r_dout_vld <= 1'b0;
      for (int unsigned k = 0; k < N; k++) begin
        r_stage[k] <= '0;
        for (int unsigned m = 0; m < M; m++) r_dly[k][m] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < N; k++) begin
        r_vld[k] <= w_v[k];
        if (w_v[k]) begin
          r_stage[k]  <= w_x[k] - r_dly[k][M-1];
          r_dly[k][0] <= w_x[k];
          for (int unsigned m = 1; m < M; m++) r_dly[k][m] <= r_dly[k][m-1];
        end
      end
      r_dout_vld <= r_vld[N-1];
      if (r_vld[N-1]) r_dout <= w_scaled;
    end
  end

`ifdef CIC_COMB_ROUND_EN
  if (SHIFT > 0) begin : g_round
    localparam logic [OW:0] MAXP = {1'b0, {OW{1'b1}}} >> 1;
    logic [OW:0] w_rnd;
    // (x + 2^(SHIFT-1)) >> SHIFT == floor(x / 2^SHIFT) + x[SHIFT-1]; only +2^(OW-1) can overflow.
    assign w_rnd    = {r_stage[N-1][IW-1], r_stage[N-1][IW-1:SHIFT]}
                    + {{OW{1'b0}}, r_stage[N-1][SHIFT-1]};
    assign w_scaled = (w_rnd[OW:OW-1] == 2'b01) ? MAXP[OW-1:0] : w_rnd[OW-1:0];
  end else begin : g_pass
    assign w_scaled = r_stage[N-1];
  end
`else
  assign w_scaled = r_stage[N-1][IW-1:SHIFT];
`endif

  assign dout     = r_dout;
  assign dout_vld = r_dout_vld;

endmodule

// File: tb/tb_cic_comb.sv
// Self-checking bench for cic_comb: four parameterisations share one stimulus stream,
// checked against a binomial-sum model of the cascaded combs plus directed cases.
module tb_cic_comb;

`ifdef CIC_COMB_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [36:0] din = '0;
  logic               din_vld = 1'b0;
  logic signed [36:0] d0, d1, d3;
  logic signed [15:0] d2;
  logic               v0, v1, v2, v3;

  int     cyc = 0;
  int     checks = 0;
  int     failures = 0;
  longint hist[$];
  int     drv[$];
  longint cap_v [4][$];
  int     cap_c [4][$];
  int     cfg_n  [4] = '{3, 1, 1, 1};
  int     cfg_m  [4] = '{1, 1, 1, 2};
  int     cfg_ow [4] = '{37, 37, 16, 37};

  cic_comb #(.IW(37), .N(3), .M(1), .OW(37)) u0 (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .dout(d0), .dout_vld(v0));
  cic_comb #(.IW(37), .N(1), .M(1), .OW(37)) u1 (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .dout(d1), .dout_vld(v1));
  cic_comb #(.IW(37), .N(1), .M(1), .OW(16)) u2 (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .dout(d2), .dout_vld(v2));
  cic_comb #(.IW(37), .N(1), .M(2), .OW(37)) u3 (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .dout(d3), .dout_vld(v3));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (v0 === 1'b1) begin cap_v[0].push_back(longint'(d0)); cap_c[0].push_back(cyc); end
    if (v1 === 1'b1) begin cap_v[1].push_back(longint'(d1)); cap_c[1].push_back(cyc); end
    if (v2 === 1'b1) begin cap_v[2].push_back(longint'(d2)); cap_c[2].push_back(cyc); end
    if (v3 === 1'b1) begin cap_v[3].push_back(longint'(d3)); cap_c[3].push_back(cyc); end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic longint sx(longint x);
    logic signed [36:0] t;
    t = x[36:0];
    return longint'(t);
  endfunction

  function automatic longint cur(int d);
    case (d)
      0: return longint'(d0);
      1: return longint'(d1);
      2: return longint'(d2);
      default: return longint'(d3);
    endcase
  endfunction

  // Cascade of n combs with delay m equals sum_j (-1)^j C(n,j) x[idx - j*m], modulo 2^37.
  function automatic longint model(int idx, int n, int m, int ow);
    longint acc, coef, t, maxp;
    logic signed [36:0] w;
    int sh;
    acc = 0;
    coef = 1;
    for (int j = 0; j <= n; j++) begin
      if (idx - j*m >= 0) acc += coef * hist[idx - j*m];
      coef = (-coef * (n - j)) / (j + 1);
    end
    w = acc[36:0];
    t = longint'(w);
    sh = 37 - ow;
    if (sh == 0) return t;
    if (RND) begin
      maxp = (longint'(1) << (ow - 1)) - 1;
      t = (t + (longint'(1) << (sh - 1))) >>> sh;
      if (t > maxp) t = maxp;
    end else begin
      t = t >>> sh;
    end
    return t;
  endfunction

  task automatic clear_caps();
    for (int d = 0; d < 4; d++) begin
      cap_v[d].delete();
      cap_c[d].delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    din_vld = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    hist.delete();
    drv.delete();
    clear_caps();
  endtask

  task automatic send(longint x, int gap);
    @(negedge clk);
    din = x[36:0];
    din_vld = 1'b1;
    hist.push_back(sx(x));
    drv.push_back(cyc);
    if (gap > 0) begin
      @(negedge clk);
      din_vld = 1'b0;
      repeat (gap - 1) @(negedge clk);
    end
  endtask

  task automatic drain();
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [3:0] vv;
    do_reset();
    vv = {v3, v2, v1, v0};
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (cur(d) !== 0) begin
        failures++;
        $display("FAIL reset_dout u%0d got=%0d exp=0", d, cur(d));
      end
      checks++;
      if (vv[d] !== 1'b0) begin
        failures++;
        $display("FAIL reset_vld u%0d got=%b exp=0", d, vv[d]);
      end
    end
  endtask

  task automatic test_impulse();
    longint exp_v[$] = '{1, -3, 3, -1, 0};
    do_reset();
    foreach (exp_v[i]) send((i == 0) ? 1 : 0, 4);
    drain();
    checks++;
    if (cap_v[0].size() !== exp_v.size()) begin
      failures++;
      $display("FAIL impulse_count got=%0d exp=%0d", cap_v[0].size(), exp_v.size());
    end else begin
      foreach (exp_v[i]) begin
        checks++;
        if (cap_v[0][i] !== exp_v[i]) begin
          failures++;
          $display("FAIL impulse_val[%0d] got=%0d exp=%0d", i, cap_v[0][i], exp_v[i]);
        end
        checks++;
        if (cap_c[0][i] - drv[i] !== 4) begin
          failures++;
          $display("FAIL impulse_latency[%0d] got=%0d exp=4", i, cap_c[0][i] - drv[i]);
        end
      end
    end
  endtask

  task automatic test_step();
    longint exp_v[$] = '{100, -200, 100, 0, 0, 0};
    do_reset();
    repeat (6) send(100, 4);
    drain();
    checks++;
    if (cap_v[0].size() !== exp_v.size()) begin
      failures++;
      $display("FAIL step_count got=%0d exp=%0d", cap_v[0].size(), exp_v.size());
    end else begin
      foreach (exp_v[i]) begin
        checks++;
        if (cap_v[0][i] !== exp_v[i]) begin
          failures++;
          $display("FAIL step_val[%0d] got=%0d exp=%0d", i, cap_v[0][i], exp_v[i]);
        end
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    send((longint'(1) << 36) - 1, 3);
    send(-(longint'(1) << 36), 3);
    drain();
    checks++;
    if (cap_v[1].size() !== 2) begin
      failures++;
      $display("FAIL wrap_count got=%0d exp=2", cap_v[1].size());
    end else begin
      checks++;
      if (cap_v[1][0] !== (longint'(1) << 36) - 1) begin
        failures++;
        $display("FAIL wrap_first got=%0d exp=%0d", cap_v[1][0], (longint'(1) << 36) - 1);
      end
      checks++;
      if (cap_v[1][1] !== 1) begin
        failures++;
        $display("FAIL wrap_second got=%0d exp=1", cap_v[1][1]);
      end
    end
  endtask

  task automatic test_scaling();
    longint exp_v[$];
    exp_v = RND ? '{0, 2, -1} : '{0, 1, -2};
    do_reset();
    send(0, 3);
    send(3 * (longint'(1) << 20), 3);
    send(0, 3);
    drain();
    checks++;
    if (cap_v[2].size() !== exp_v.size()) begin
      failures++;
      $display("FAIL scale_count got=%0d exp=%0d", cap_v[2].size(), exp_v.size());
    end else begin
      foreach (exp_v[i]) begin
        checks++;
        if (cap_v[2][i] !== exp_v[i]) begin
          failures++;
          $display("FAIL scale_val[%0d] got=%0d exp=%0d", i, cap_v[2][i], exp_v[i]);
        end
      end
    end
  endtask

  task automatic test_round_sat();
    do_reset();
    send(0, 3);
    send((longint'(1) << 36) - 1, 3);
    drain();
    checks++;
    if (cap_v[2].size() !== 2) begin
      failures++;
      $display("FAIL sat_count got=%0d exp=2", cap_v[2].size());
    end else begin
      checks++;
      if (cap_v[2][1] !== 32767) begin
        failures++;
        $display("FAIL sat_val got=%0d exp=32767", cap_v[2][1]);
      end
    end
  endtask

  task automatic test_back_to_back();
    longint exp_v[$] = '{5, 2, 0, -5};
    do_reset();
    send(5, 0);
    send(7, 0);
    send(7, 0);
    send(2, 3);
    drain();
    checks++;
    if (cap_v[1].size() !== exp_v.size()) begin
      failures++;
      $display("FAIL b2b_count got=%0d exp=%0d", cap_v[1].size(), exp_v.size());
    end else begin
      foreach (exp_v[i]) begin
        checks++;
        if (cap_v[1][i] !== exp_v[i]) begin
          failures++;
          $display("FAIL b2b_val[%0d] got=%0d exp=%0d", i, cap_v[1][i], exp_v[i]);
        end
        checks++;
        if (cap_c[1][i] !== drv[0] + 2 + i) begin
          failures++;
          $display("FAIL b2b_cycle[%0d] got=%0d exp=%0d", i, cap_c[1][i], drv[0] + 2 + i);
        end
      end
    end
    // Two samples in flight when reset hits: neither may reach the output.
    clear_caps();
    @(negedge clk);
    din = 37'sd11;
    din_vld = 1'b1;
    @(negedge clk);
    din = 37'sd13;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    din_vld = 1'b0;
    hist.delete();
    drv.delete();
    repeat (6) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (cap_v[d].size() !== 0) begin
        failures++;
        $display("FAIL flush_vld u%0d got=%0d strobes exp=0", d, cap_v[d].size());
      end
      checks++;
      if (cur(d) !== 0) begin
        failures++;
        $display("FAIL flush_dout u%0d got=%0d exp=0", d, cur(d));
      end
    end
    clear_caps();
    send(9, 3);
    drain();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (cap_v[d].size() !== 1) begin
        failures++;
        $display("FAIL post_reset_count u%0d got=%0d exp=1", d, cap_v[d].size());
      end else begin
        checks++;
        if (cap_v[d][0] !== 9) begin
          failures++;
          $display("FAIL post_reset_val u%0d got=%0d exp=9", d, cap_v[d][0]);
        end
      end
    end
  endtask

  task automatic test_diff_delay();
    longint exp_v[$] = '{1, 2, 3, 6};
    do_reset();
    send(1, 2);
    send(2, 2);
    send(4, 2);
    send(8, 2);
    drain();
    checks++;
    if (cap_v[3].size() !== exp_v.size()) begin
      failures++;
      $display("FAIL m2_count got=%0d exp=%0d", cap_v[3].size(), exp_v.size());
    end else begin
      foreach (exp_v[i]) begin
        checks++;
        if (cap_v[3][i] !== exp_v[i]) begin
          failures++;
          $display("FAIL m2_val[%0d] got=%0d exp=%0d", i, cap_v[3][i], exp_v[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    longint x, e;
    int n;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0: x = sx({$urandom, $urandom});
        1: x = longint'($urandom_range(0, 200)) - 100;
        2: x = ($urandom_range(0, 1) == 1) ? (longint'(1) << 36) - 1 : -(longint'(1) << 36);
        default: x = 0;
      endcase
      send(x, (i == 59) ? 3 : int'($urandom_range(0, 3)));
    end
    repeat (10) @(negedge clk);
    n = hist.size();
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (cap_v[d].size() !== n) begin
        failures++;
        $display("FAIL rand_count u%0d got=%0d exp=%0d", d, cap_v[d].size(), n);
        continue;
      end
      for (int i = 0; i < n; i++) begin
        e = model(i, cfg_n[d], cfg_m[d], cfg_ow[d]);
        checks++;
        if (cap_v[d][i] !== e) begin
          failures++;
          $display("FAIL rand_val u%0d[%0d] got=%0d exp=%0d", d, i, cap_v[d][i], e);
        end
        checks++;
        if (cap_c[d][i] - drv[i] !== cfg_n[d] + 1) begin
          failures++;
          $display("FAIL rand_latency u%0d[%0d] got=%0d exp=%0d", d, i,
                   cap_c[d][i] - drv[i], cfg_n[d] + 1);
        end
      end
      e = model(n - 1, cfg_n[d], cfg_m[d], cfg_ow[d]);
      checks++;
      if (cur(d) !== e) begin
        failures++;
        $display("FAIL rand_hold u%0d got=%0d exp=%0d", d, cur(d), e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_step();
    test_wrap();
    test_scaling();
    test_round_sat();
    test_back_to_back();
    test_diff_delay();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
